pipe_main_control: RTL

Parametrised, pipelined successor to the single-cycle main decoder of the Pipelined RISC Toy. It decodes the ID-stage opcode and carries the resulting control word through ID/EX, EX/MEM and MEM/WB registers. It also performs load-use interlocking, redirect flushing and memory-busy freezing. It sits beside the datapath pipeline registers and drives every stage's control inputs.

---
 rtl/pipe_main_control.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_main_control.sv
// pipe_main_control: pipelined main decoder. Decodes the ID opcode and
// carries the control word through ID/EX, EX/MEM and MEM/WB. It also handles
// load-use interlock, redirect flush and memory-busy freeze.
module pipe_main_control #(
    parameter int OPW  = 5,
    parameter int ALUW = 5,
    parameter int REGW = 5,
    parameter int SCW  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [OPW-1:0]  id_opcode,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_rs1_en,
    input  logic            id_rs2_en,
    input  logic [REGW-1:0] id_rd,
    input  logic            ex_redirect,
    input  logic            mem_busy,
    output logic            id_jump,
    output logic            id_illegal,
    output logic            stall_if_id,
    output logic            flush_if_id,
    output logic            ex_valid,
    output logic            ex_alusrc,
    output logic            ex_regdst,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [ALUW-1:0] ex_aluctrl,
    output logic [REGW-1:0] ex_rd,
    output logic [REGW-1:0] mem_rd,
    output logic [REGW-1:0] wb_rd,
    output logic            mem_valid,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            mem_ldrstr,
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic            illegal_flag,
    output logic [SCW-1:0]  stall_count
);

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
        logic ldrstr;
        logic alusrc;
        logic regdst;
        logic branch;
        logic jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: 1'b0};

    // Control word for a legal 5-bit opcode; the 11xxx space yields all zeros.
    function automatic ctrl_t decode_op(input logic [4:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op) inside
            [5'd0:5'd3]:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
            [5'd4:5'd14]: c.regwrite = 1'b1;
            5'd15:        c = CTRL_NONE;
            5'd16, 5'd17: c.jump = 1'b1;
            5'd18:        begin c.jump = 1'b1; c.regwrite = 1'b1; end
            5'd19:        begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.memread = 1'b1; c.alusrc = 1'b1; end
            5'd20:        begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.memread = 1'b1; c.ldrstr = 1'b1; end
            5'd21:        begin c.memwrite = 1'b1; c.alusrc = 1'b1; c.regdst = 1'b1; end
            5'd22:        begin c.memwrite = 1'b1; c.ldrstr = 1'b1; c.regdst = 1'b1; end
            5'd23:        c.branch = 1'b1;
            default:      c = CTRL_NONE;
        endcase
        return c;
    endfunction

    // ID/EX state
    logic            ex_valid_r;
    ctrl_t           ex_ctrl_r;
    logic [ALUW-1:0] ex_aluctrl_r;
    logic [REGW-1:0] ex_rd_r;
    // EX/MEM state
    logic            mem_valid_r, mem_regwrite_r, mem_memtoreg_r;
    logic            mem_memread_r, mem_memwrite_r, mem_ldrstr_r;
    logic [REGW-1:0] mem_rd_r;
    // MEM/WB state
    logic            wb_valid_r, wb_regwrite_r, wb_memtoreg_r;
    logic [REGW-1:0] wb_rd_r;
    // Status
    logic            illegal_flag_r;
    logic [SCW-1:0]  stall_count_r;

    // Combinational decode and hazard terms
    logic            id_hi_s;
    logic            id_illegal_s;
    ctrl_t           id_ctrl_s;
    logic [ALUW-1:0] id_aluctrl_s;
    logic            load_use_s;
    logic            idex_bubble_s;
    logic            stall_s;
    logic            flush_s;

    // Opcode bits above bit 4 only exist for wide opcodes.
    if (OPW > 5) begin : g_hi
        assign id_hi_s = |id_opcode[OPW-1:5];
    end else begin : g_nohi
        assign id_hi_s = 1'b0;
    end

    // The ALU control field is the opcode, zero-extended or truncated.
    if (ALUW <= OPW) begin : g_alu_trunc
        assign id_aluctrl_s = id_opcode[ALUW-1:0];
    end else begin : g_alu_ext
        assign id_aluctrl_s = {{(ALUW-OPW){1'b0}}, id_opcode};
    end

    // Decode the ID opcode; illegal opcodes carry no control bits.
    always_comb begin
        id_illegal_s = id_hi_s | (id_opcode[4:3] == 2'b11);
        id_ctrl_s    = CTRL_NONE;
        if (id_illegal_s) begin
            id_ctrl_s = CTRL_NONE;
        end else begin
            id_ctrl_s = decode_op(id_opcode[4:0]);
        end
    end

    // Hazard detection and pipeline steering. Priority: busy > redirect > load-use.
    always_comb begin
        load_use_s    = 1'b0;
        stall_s       = 1'b0;
        flush_s       = 1'b0;
        idex_bubble_s = 1'b0;
        if (id_valid && ex_valid_r && ex_ctrl_r.memread &&
            ((id_rs1_en && (id_rs1 == ex_rd_r)) || (id_rs2_en && (id_rs2 == ex_rd_r)))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
        if (mem_busy) begin
            stall_s = 1'b1;
        end else if (ex_redirect) begin
            flush_s       = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (load_use_s) begin
            stall_s       = 1'b1;
            idex_bubble_s = 1'b1;
        end else begin
            idex_bubble_s = ~id_valid | id_illegal_s;
        end
    end

    // ID/EX register: loads decoded control or a bubble, holds while memory is busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_r   <= 1'b0;
            ex_ctrl_r    <= CTRL_NONE;
            ex_aluctrl_r <= {ALUW{1'b0}};
            ex_rd_r      <= {REGW{1'b0}};
        end else if (!mem_busy) begin
            if (idex_bubble_s) begin
                ex_valid_r   <= 1'b0;
                ex_ctrl_r    <= CTRL_NONE;
                ex_aluctrl_r <= {ALUW{1'b0}};
                ex_rd_r      <= {REGW{1'b0}};
            end else begin
                ex_valid_r   <= 1'b1;
                ex_ctrl_r    <= id_ctrl_s;
                ex_aluctrl_r <= id_aluctrl_s;
                ex_rd_r      <= id_rd;
            end
        end
    end

    // EX/MEM register: memory and writeback bits plus rd from ID/EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid_r    <= 1'b0;
            mem_regwrite_r <= 1'b0;
            mem_memtoreg_r <= 1'b0;
            mem_memread_r  <= 1'b0;
            mem_memwrite_r <= 1'b0;
            mem_ldrstr_r   <= 1'b0;
            mem_rd_r       <= {REGW{1'b0}};
        end else if (!mem_busy) begin
            mem_valid_r    <= ex_valid_r;
            mem_regwrite_r <= ex_ctrl_r.regwrite;
            mem_memtoreg_r <= ex_ctrl_r.memtoreg;
            mem_memread_r  <= ex_ctrl_r.memread;
            mem_memwrite_r <= ex_ctrl_r.memwrite;
            mem_ldrstr_r   <= ex_ctrl_r.ldrstr;
            mem_rd_r       <= ex_rd_r;
        end
    end

    // MEM/WB register: writeback bits plus rd from EX/MEM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_r    <= 1'b0;
            wb_regwrite_r <= 1'b0;
            wb_memtoreg_r <= 1'b0;
            wb_rd_r       <= {REGW{1'b0}};
        end else if (!mem_busy) begin
            wb_valid_r    <= mem_valid_r;
            wb_regwrite_r <= mem_regwrite_r;
            wb_memtoreg_r <= mem_memtoreg_r;
            wb_rd_r       <= mem_rd_r;
        end
    end

    // Sticky illegal flag, set when an illegal opcode would have entered EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_flag_r <= 1'b0;
        end else if (!mem_busy && !ex_redirect && !load_use_s && id_valid && id_illegal_s) begin
            illegal_flag_r <= 1'b1;
        end
    end

    // Saturating count of cycles spent in a load-use stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_r <= {SCW{1'b0}};
        end else if (!mem_busy && !ex_redirect && load_use_s &&
                     (stall_count_r != {SCW{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(SCW-1){1'b0}}, 1'b1};
        end
    end

    assign id_jump      = id_ctrl_s.jump;
    assign id_illegal   = id_illegal_s;
    assign stall_if_id  = stall_s;
    assign flush_if_id  = flush_s;
    assign ex_valid     = ex_valid_r;
    assign ex_alusrc    = ex_ctrl_r.alusrc;
    assign ex_regdst    = ex_ctrl_r.regdst;
    assign ex_branch    = ex_ctrl_r.branch;
    assign ex_jump      = ex_ctrl_r.jump;
    assign ex_aluctrl   = ex_aluctrl_r;
    assign ex_rd        = ex_rd_r;
    assign mem_rd       = mem_rd_r;
    assign wb_rd        = wb_rd_r;
    assign mem_valid    = mem_valid_r;
    assign mem_memread  = mem_memread_r;
    assign mem_memwrite = mem_memwrite_r;
    assign mem_ldrstr   = mem_ldrstr_r;
    assign wb_valid     = wb_valid_r;
    assign wb_regwrite  = wb_regwrite_r;
    assign wb_memtoreg  = wb_memtoreg_r;
    assign illegal_flag = illegal_flag_r;
    assign stall_count  = stall_count_r;

endmodule
